// File: rtl/accum_if.sv
// Handshake bundle between the multiplier array, the accumulator sequencer and the
// downstream activation stage.
interface accum_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 5
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_sat;
    logic              out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_sat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_sat
    );
endinterface

// File: rtl/accum_sequencer.sv
// Sequences one dense-layer pass: per neuron, saturating accumulation of VEC_LEN
// product beats, then a held result until downstream accepts it.
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | accepting product beats into the running sum
// EMIT  | result presented, waiting for out_ready
// DONE  | one-cycle layer_done pulse
module accum_sequencer #(
    parameter int DATA_W  = 16,
    parameter int VEC_LEN = 133,
    parameter int NUM_OUT = 16,
    parameter int CNT_W   = 8,
    parameter int IDX_W   = 5
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    accum_if.slave bus,
    output logic   busy,
    output logic   layer_done
);
    typedef enum logic [1:0] {IDLE, ACCUM, EMIT, DONE} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  elem_cnt;
    logic [IDX_W-1:0]  neuron;
    logic              sat;
    logic [DATA_W-1:0] out_data_r;
    logic [IDX_W-1:0]  out_idx_r;
    logic              out_sat_r;

    logic [DATA_W:0]   sum_ext;
    logic [DATA_W-1:0] sum_sat;
    logic              ovf;
    logic              accept;
    logic              last_elem;
    logic              last_neuron;

    // Sign-extended add; overflow when the two top bits disagree.
    assign sum_ext     = {acc[DATA_W-1], acc} + {bus.in_data[DATA_W-1], bus.in_data};
    assign ovf         = sum_ext[DATA_W] ^ sum_ext[DATA_W-1];
    assign sum_sat     = !ovf            ? sum_ext[DATA_W-1:0] :
                         sum_ext[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} :
                                           {1'b0, {(DATA_W-1){1'b1}}};
    assign accept      = (state == ACCUM) && bus.in_valid;
    assign last_elem   = (elem_cnt == CNT_W'(VEC_LEN - 1));
    assign last_neuron = (neuron == IDX_W'(NUM_OUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (accept && last_elem) state_nxt = EMIT;
            EMIT:    if (bus.out_ready) state_nxt = last_neuron ? DONE : ACCUM;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            elem_cnt   <= '0;
            neuron     <= '0;
            sat        <= 1'b0;
            out_data_r <= '0;
            out_idx_r  <= '0;
            out_sat_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        elem_cnt <= '0;
                        neuron   <= '0;
                        sat      <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= sum_sat;
                        sat <= sat | ovf;
                        if (last_elem) begin
                            elem_cnt   <= '0;
                            out_data_r <= sum_sat;
                            out_idx_r  <= neuron;
                            out_sat_r  <= sat | ovf;
                        end else begin
                            elem_cnt <= elem_cnt + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (bus.out_ready && !last_neuron) begin
                        neuron   <= neuron + 1'b1;
                        acc      <= '0;
                        elem_cnt <= '0;
                        sat      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == EMIT);
    assign bus.out_data  = out_data_r;
    assign bus.out_idx   = out_idx_r;
    assign bus.out_sat   = out_sat_r;
    assign busy          = (state != IDLE);
    assign layer_done    = (state == DONE);
endmodule

// File: tb/tb_accum_sequencer.sv
// Directed bench: a small instance (VEC_LEN=4, NUM_OUT=2) for the sequencing cases
// and a default-parameter instance for the full-length pass.
module tb_accum_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_s = 1'b0;
    logic start_d = 1'b0;
    logic busy_s, done_s, busy_d, done_d;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    accum_if #(.DATA_W(16), .IDX_W(5)) bus_s ();
    accum_if #(.DATA_W(16), .IDX_W(5)) bus_d ();

    accum_sequencer #(.DATA_W(16), .VEC_LEN(4), .NUM_OUT(2), .CNT_W(8), .IDX_W(5)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .bus(bus_s.slave),
        .busy(busy_s), .layer_done(done_s)
    );

    accum_sequencer dut_d (
        .clk(clk), .rst(rst), .start(start_d), .bus(bus_d.slave),
        .busy(busy_d), .layer_done(done_d)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_s(input logic [15:0] d);
        bus_s.in_valid = 1'b1;
        bus_s.in_data  = d;
        tick();
        bus_s.in_valid = 1'b0;
        bus_s.in_data  = 16'h0;
    endtask

    task automatic pulse_start_s();
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (bus_s.in_ready !== 1'b0)  begin bad++; $display("FAIL rst_in_ready got=%b exp=0", bus_s.in_ready); end
        total++; if (bus_s.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus_s.out_valid); end
        total++; if (bus_s.out_data !== 16'h0) begin bad++; $display("FAIL rst_out_data got=%h exp=0000", bus_s.out_data); end
        total++; if (busy_s !== 1'b0 || done_s !== 1'b0) begin bad++; $display("FAIL rst_busy_done got=%b%b exp=00", busy_s, done_s); end
        total++; if (busy_d !== 1'b0 || bus_d.in_ready !== 1'b0) begin bad++; $display("FAIL rst_dflt got=%b%b exp=00", busy_d, bus_d.in_ready); end
    endtask

    task automatic test_basic();
        bus_s.out_ready = 1'b1;
        pulse_start_s();
        total++; if (busy_s !== 1'b1 || bus_s.in_ready !== 1'b1) begin bad++; $display("FAIL basic_accum got=%b%b exp=11", busy_s, bus_s.in_ready); end
        beat_s(16'd1); beat_s(16'd2); beat_s(16'd3);
        total++; if (bus_s.out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", bus_s.out_valid); end
        beat_s(16'd4);
        total++; if (bus_s.out_valid !== 1'b1 || bus_s.out_data !== 16'd10) begin bad++; $display("FAIL basic_n0 got=%b/%h exp=1/000a", bus_s.out_valid, bus_s.out_data); end
        total++; if (bus_s.out_idx !== 5'd0 || bus_s.out_sat !== 1'b0) begin bad++; $display("FAIL basic_n0_idx_sat got=%0d/%b exp=0/0", bus_s.out_idx, bus_s.out_sat); end
        tick();
        total++; if (bus_s.out_valid !== 1'b0 || bus_s.in_ready !== 1'b1) begin bad++; $display("FAIL basic_no_gap got=%b%b exp=01", bus_s.out_valid, bus_s.in_ready); end
        for (int i = 0; i < 4; i++) beat_s(16'd5);
        total++; if (bus_s.out_data !== 16'd20 || bus_s.out_idx !== 5'd1) begin bad++; $display("FAIL basic_n1 got=%h/%0d exp=0014/1", bus_s.out_data, bus_s.out_idx); end
        total++; if (done_s !== 1'b0) begin bad++; $display("FAIL basic_done_early got=%b exp=0", done_s); end
        tick();
        total++; if (done_s !== 1'b1 || busy_s !== 1'b1) begin bad++; $display("FAIL basic_done got=%b%b exp=11", done_s, busy_s); end
        tick();
        total++; if (done_s !== 1'b0 || busy_s !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b%b exp=00", done_s, busy_s); end
    endtask

    task automatic test_backpressure();
        bus_s.out_ready = 1'b0;
        pulse_start_s();
        beat_s(16'd1); beat_s(16'd2); beat_s(16'd3); beat_s(16'd4);
        for (int i = 0; i < 5; i++) begin
            bus_s.in_valid = 1'b1;
            bus_s.in_data  = 16'd100;
            total++; if (bus_s.out_valid !== 1'b1 || bus_s.out_data !== 16'd10 || bus_s.in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d got=%b/%h/%b exp=1/000a/0", i, bus_s.out_valid, bus_s.out_data, bus_s.in_ready);
            end
            tick();
        end
        bus_s.in_valid  = 1'b0;
        bus_s.out_ready = 1'b1;
        tick();
        total++; if (bus_s.in_ready !== 1'b1 || bus_s.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b%b exp=10", bus_s.in_ready, bus_s.out_valid); end
        for (int i = 0; i < 4; i++) beat_s(16'd5);
        total++; if (bus_s.out_data !== 16'd20) begin bad++; $display("FAIL bp_not_consumed got=%h exp=0014", bus_s.out_data); end
        tick();
        tick();
    endtask

    task automatic test_bubbles();
        logic        v[7];
        logic [15:0] d[7];
        v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        d = '{16'd7, 16'h1234, 16'h4321, 16'hFFFE, 16'd3, 16'h0BAD, 16'd1};
        bus_s.out_ready = 1'b0;
        pulse_start_s();
        for (int i = 0; i < 7; i++) begin
            bus_s.in_valid = v[i];
            bus_s.in_data  = d[i];
            tick();
            if (i == 5) begin
                total++; if (bus_s.out_valid !== 1'b0) begin bad++; $display("FAIL bub_early got=%b exp=0", bus_s.out_valid); end
            end
        end
        bus_s.in_valid = 1'b0;
        total++; if (bus_s.out_valid !== 1'b1 || bus_s.out_data !== 16'd9) begin bad++; $display("FAIL bub_sum got=%b/%h exp=1/0009", bus_s.out_valid, bus_s.out_data); end
        pulse_rst();
    endtask

    task automatic test_saturation();
        bus_s.out_ready = 1'b1;
        pulse_start_s();
        for (int i = 0; i < 4; i++) beat_s(16'h7000);
        total++; if (bus_s.out_data !== 16'h7FFF || bus_s.out_sat !== 1'b1) begin bad++; $display("FAIL sat_pos got=%h/%b exp=7fff/1", bus_s.out_data, bus_s.out_sat); end
        tick();
        for (int i = 0; i < 4; i++) beat_s(16'h9000);
        total++; if (bus_s.out_data !== 16'h8000 || bus_s.out_sat !== 1'b1) begin bad++; $display("FAIL sat_neg got=%h/%b exp=8000/1", bus_s.out_data, bus_s.out_sat); end
        tick();
        tick();
        pulse_start_s();
        beat_s(16'h7000); beat_s(16'h7000); beat_s(16'h9000); beat_s(16'h0000);
        total++; if (bus_s.out_data !== 16'h0FFF || bus_s.out_sat !== 1'b1) begin bad++; $display("FAIL sat_recover got=%h/%b exp=0fff/1", bus_s.out_data, bus_s.out_sat); end
        tick();
        for (int i = 0; i < 4; i++) beat_s(16'd1);
        total++; if (bus_s.out_data !== 16'd4 || bus_s.out_sat !== 1'b0) begin bad++; $display("FAIL sat_sticky_clr got=%h/%b exp=0004/0", bus_s.out_data, bus_s.out_sat); end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        bus_s.out_ready = 1'b0;
        pulse_start_s();
        beat_s(16'd1); beat_s(16'd1);
        pulse_rst();
        total++; if (busy_s !== 1'b0 || bus_s.in_ready !== 1'b0 || bus_s.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_ctl got=%b%b%b exp=000", busy_s, bus_s.in_ready, bus_s.out_valid); end
        total++; if (bus_s.out_data !== 16'h0 || bus_s.out_idx !== 5'd0 || bus_s.out_sat !== 1'b0) begin bad++; $display("FAIL rmid_data got=%h/%0d/%b exp=0000/0/0", bus_s.out_data, bus_s.out_idx, bus_s.out_sat); end
        pulse_start_s();
        for (int i = 0; i < 4; i++) beat_s(16'd1);
        total++; if (bus_s.out_data !== 16'd4 || bus_s.out_idx !== 5'd0) begin bad++; $display("FAIL rmid_restart got=%h/%0d exp=0004/0", bus_s.out_data, bus_s.out_idx); end
        pulse_rst();
    endtask

    task automatic test_defaults();
        bus_d.out_ready = 1'b1;
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        for (int i = 0; i < 133; i++) begin
            bus_d.in_valid = 1'b1;
            bus_d.in_data  = 16'h0001;
            start_d = (i == 60);
            tick();
            if (i == 131) begin
                total++; if (bus_d.out_valid !== 1'b0) begin bad++; $display("FAIL dflt_early got=%b exp=0", bus_d.out_valid); end
            end
        end
        start_d        = 1'b0;
        bus_d.in_valid = 1'b0;
        total++; if (bus_d.out_valid !== 1'b1 || bus_d.out_data !== 16'h0085 || bus_d.out_idx !== 5'd0) begin
            bad++; $display("FAIL dflt_sum got=%b/%h/%0d exp=1/0085/0", bus_d.out_valid, bus_d.out_data, bus_d.out_idx);
        end
        pulse_rst();
    endtask

    initial begin
        bus_s.in_valid = 1'b0; bus_s.in_data = 16'h0; bus_s.out_ready = 1'b0;
        bus_d.in_valid = 1'b0; bus_d.in_data = 16'h0; bus_d.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_bubbles();
        test_saturation();
        test_reset_mid();
        test_defaults();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
